// File: rtl/hazard_unit_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and defaults for the hazard unit.
// Rev    : 1.0
// ============================================================================
package hazard_pkg;

  localparam int unsigned c_def_reg_addr_w = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Pending-write bits and in-flight count for multi-cycle ops.
// Rev    : 1.0
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = c_def_reg_addr_w,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  long_d,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  long_done,
  input  logic [REG_ADDR_W-1:0] long_rd,
  output logic                  busy,
  output logic                  full
);

  localparam int unsigned c_num_regs = 2 ** REG_ADDR_W;
  localparam int unsigned c_cnt_w    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_OUTSTANDING);

  logic [c_num_regs-1:0] r_pending;
  logic [c_num_regs-1:0] w_set;
  logic [c_num_regs-1:0] w_clr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  w_dec;

  // A completion with nothing in flight is stray and must not underflow.
  assign w_dec = long_done && (r_count != '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue && (issue_rd != '0)) w_set[issue_rd] = 1'b1;
    if (long_done)                 w_clr[long_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (issue && !w_dec)
        r_count <= r_count + c_cnt_w'(1);
      else if (w_dec && !issue)
        r_count <= r_count - c_cnt_w'(1);
    end
  end

  assign busy = r_pending[rs1_d] | r_pending[rs2_d] |
                (r_pending[rd_d] && (rd_d != '0));
  assign full = long_d && (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit_sb
// Brief  : Forwarding, load-use/scoreboard stalls, flushes, stall counter.
// Rev    : 1.0
// ============================================================================
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = c_def_reg_addr_w,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  long_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  valid_e,
  input  logic                  mem_read_e,
  input  logic                  long_e,
  input  logic                  pc_src_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic                  long_done,
  input  logic [REG_ADDR_W-1:0] long_rd,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic [REG_ADDR_W-1:0] w_rs_e [2];
  logic                  w_issue;
  logic                  w_lu;
  logic                  w_el;
  logic                  w_sb_busy;
  logic                  w_full;
  logic                  w_stall;
  logic [CNT_W-1:0]      r_stall_cycles;

  assign w_rs_e[0] = rs1_e;
  assign w_rs_e[1] = rs2_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel_t w_sel;
      always_comb begin
        w_sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == w_rs_e[gi]))
          w_sel = FWD_M;
        else if (reg_write_w && (rd_w != '0) && (rd_w == w_rs_e[gi]))
          w_sel = FWD_W;
      end
    end
  endgenerate

  assign forward_a_e = g_fwd[0].w_sel;
  assign forward_b_e = g_fwd[1].w_sel;

  assign w_issue = valid_e && long_e;
  assign w_lu    = valid_e && mem_read_e && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
  // Issue-cycle hazard: the pending bit only appears after this edge.
  assign w_el    = w_issue && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d) || (rd_e == rd_d));

  hazard_scoreboard #(
    .REG_ADDR_W      (REG_ADDR_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_d     (rs1_d),
    .rs2_d     (rs2_d),
    .rd_d      (rd_d),
    .long_d    (long_d),
    .issue     (w_issue),
    .issue_rd  (rd_e),
    .long_done (long_done),
    .long_rd   (long_rd),
    .busy      (w_sb_busy),
    .full      (w_full)
  );

  assign w_stall = w_lu | w_el | w_sb_busy | w_full;

  // A redirect must load the new PC, so flush beats stall.
  assign stall_f = w_stall && !pc_src_e;
  assign stall_d = w_stall && !pc_src_e;
  assign flush_e = w_stall | pc_src_e;
  assign flush_d = pc_src_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (stall_d && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_sb.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_unit_sb
// Brief  : Directed and randomized checks of hazard_unit_sb against a model.
// Rev    : 1.0
// ============================================================================
module tb_hazard_unit_sb;

  localparam int AW   = 5;
  localparam int MAXO = 2;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd;
  logic          long_d, valid_e, mem_read_e, long_e, pc_src_e;
  logic          reg_write_m, reg_write_w, long_done;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_unit_sb #(
    .REG_ADDR_W(AW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .long_d(long_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .valid_e(valid_e), .mem_read_e(mem_read_e), .long_e(long_e),
    .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .long_done(long_done),
    .long_rd(long_rd), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .stall_cycles(stall_cycles)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference state: register busy flags, in-flight op count, stall tally.
  bit m_pend [32];
  int m_cnt;
  int m_stc;
  int oq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd(int rs, bit wm, int rdm, bit ww, int rdw);
    if (wm && rdm != 0 && rdm == rs) return 2;
    if (ww && rdw != 0 && rdw == rs) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit lu, el, sb, fu;
    lu = valid_e && mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    el = valid_e && long_e && rd_e != 0 &&
         (rd_e == rs1_d || rd_e == rs2_d || rd_e == rd_d);
    sb = m_pend[rs1_d] || m_pend[rs2_d] || (m_pend[rd_d] && rd_d != 0);
    fu = long_d && (m_cnt == MAXO);
    return lu || el || sb || fu;
  endfunction

  task automatic check_all(input string tag);
    bit s, br;
    s  = m_stall();
    br = pc_src_e;
    chk({tag, ".fa"}, forward_a_e, fwd(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w));
    chk({tag, ".fb"}, forward_b_e, fwd(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w));
    chk({tag, ".sf"}, stall_f, s && !br);
    chk({tag, ".sd"}, stall_d, s && !br);
    chk({tag, ".fd"}, flush_d, br);
    chk({tag, ".fe"}, flush_e, s || br);
    chk({tag, ".sc"}, stall_cycles, m_stc);
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_cnt = 0;
    m_stc = 0;
  endtask

  task automatic model_edge();
    bit s, iss, dn;
    s   = m_stall() && !pc_src_e;
    iss = valid_e && long_e;
    dn  = long_done && m_cnt > 0;
    if (long_done) m_pend[long_rd] = 0;
    if (iss && rd_e != 0) m_pend[rd_e] = 1;
    m_cnt = m_cnt + int'(iss) - int'(dn);
    if (s && m_stc < CMAX) m_stc++;
  endtask

  task automatic settle(input string tag);
    #4;
    check_all(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input string tag);
    settle(tag);
    edge_step();
  endtask

  task automatic clear_in();
    {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd} = '0;
    {long_d, valid_e, mem_read_e, long_e, pc_src_e} = '0;
    {reg_write_m, reg_write_w, long_done} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    model_reset();
    #12;
    check_all("reset");
    chk("reset.sd", stall_d, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Forwarding priority and x0 exclusion
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
    settle("fwd.m"); chk("fwd.m.a", forward_a_e, 2'b10); edge_step();
    reg_write_m = 0;
    settle("fwd.w"); chk("fwd.w.a", forward_a_e, 2'b01); edge_step();
    reg_write_m = 1; rd_m = 0; rd_w = 0; rs2_e = 0;
    settle("fwd.x0"); chk("fwd.x0.b", forward_b_e, 2'b00); edge_step();

    // Load-use stall
    clear_in(); valid_e = 1; mem_read_e = 1; rd_e = 7; rs2_d = 7;
    settle("lu"); chk("lu.sd", stall_d, 1); chk("lu.fd", flush_d, 0); edge_step();
    clear_in();
    settle("lu.after"); chk("lu.sc", stall_cycles, 1); edge_step();

    // Branch overrides load-use
    valid_e = 1; mem_read_e = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
    settle("br"); chk("br.sd", stall_d, 0); chk("br.fe", flush_e, 1); edge_step();
    clear_in();
    settle("br.after"); chk("br.sc", stall_cycles, 1); edge_step();

    // Scoreboard: issue rd 9, reader stalls until the cycle after long_done
    valid_e = 1; long_e = 1; rd_e = 9; rs1_d = 9;
    settle("sb.c0"); chk("sb.c0.sd", stall_d, 1); edge_step();
    valid_e = 0; long_e = 0; rd_e = 0;
    for (int c = 1; c <= 4; c++) begin
      settle("sb.wait"); chk("sb.wait.sd", stall_d, 1); edge_step();
    end
    long_done = 1; long_rd = 9;
    settle("sb.c5"); chk("sb.c5.sd", stall_d, 1); edge_step();
    long_done = 0; long_rd = 0;
    settle("sb.c6"); chk("sb.c6.sd", stall_d, 0); edge_step();

    // Same-register issue and completion: set wins
    clear_in(); valid_e = 1; long_e = 1; rd_e = 9;
    cycle("sw.a");
    long_done = 1; long_rd = 9;
    cycle("sw.b");
    clear_in(); rs1_d = 9;
    settle("sw.c"); chk("sw.c.sd", stall_d, 1); edge_step();
    clear_in(); long_done = 1; long_rd = 9;
    cycle("sw.d");
    clear_in(); rs1_d = 9;
    settle("sw.e"); chk("sw.e.sd", stall_d, 0); edge_step();

    // Structural: two in flight blocks a third long op in decode
    clear_in(); valid_e = 1; long_e = 1; rd_e = 3;
    cycle("st.i3");
    rd_e = 4;
    cycle("st.i4");
    clear_in(); long_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 10;
    for (int c = 0; c < 2; c++) begin
      settle("st.full"); chk("st.full.sd", stall_d, 1); edge_step();
    end
    long_done = 1; long_rd = 3;
    settle("st.done"); chk("st.done.sd", stall_d, 1); edge_step();
    long_done = 0; long_rd = 0;
    settle("st.rel"); chk("st.rel.sd", stall_d, 0); edge_step();
    clear_in(); long_done = 1; long_rd = 4;
    cycle("st.drain");

    // Asynchronous reset mid-operation
    clear_in(); valid_e = 1; long_e = 1; rd_e = 9;
    cycle("rst.issue");
    clear_in(); rs1_d = 9;
    settle("rst.pre"); chk("rst.pre.sd", stall_d, 1);
    #2; rst_n = 1'b0; #1;
    model_reset();
    check_all("rst.async");
    chk("rst.async.sd", stall_d, 0);
    chk("rst.async.sc", stall_cycles, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("rst.lost");
    clear_in(); long_done = 1; long_rd = 5;
    cycle("rst.stray");
    clear_in(); valid_e = 1; long_e = 1; rd_e = 11;
    cycle("rst.i11");
    rd_e = 12;
    cycle("rst.i12");
    clear_in(); long_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 10;
    settle("rst.full"); chk("rst.full.sd", stall_d, 1); edge_step();
    clear_in(); long_done = 1; long_rd = 11;
    cycle("rst.d11");
    long_rd = 12;
    cycle("rst.d12");

    // Randomized legal traffic
    clear_in();
    rst_n = 1'b0; #1; model_reset(); oq.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int r;
      clear_in();
      rs1_d = AW'($urandom_range(0, 7));  rs2_d = AW'($urandom_range(0, 7));
      rd_d  = AW'($urandom_range(0, 7));  long_d = ($urandom_range(0, 3) == 0);
      rs1_e = AW'($urandom_range(0, 7));  rs2_e = AW'($urandom_range(0, 7));
      rd_m  = AW'($urandom_range(0, 7));  rd_w  = AW'($urandom_range(0, 7));
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      rd_e  = AW'($urandom_range(0, 7));
      valid_e = 1'($urandom_range(0, 1));
      if (oq.size() > 0 && $urandom_range(0, 2) == 0) begin
        long_done = 1;
        long_rd = AW'(oq.pop_front());
      end
      r = int'($urandom_range(0, 3));
      if (r == 0) mem_read_e = 1;
      else if (r == 1) begin
        long_e = 1;
        if (valid_e) begin
          if (m_cnt < MAXO) oq.push_back(int'(rd_e));
          else long_e = 0;
        end
      end
      pc_src_e = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
